// File: rtl/glb_host_dma.sv
// Host<->GLB DMA engine: streams a load job into GLB, kicks the accelerator, drains results back.
// Optional feature macro GLB_DMA_CHKSUM_EN adds a per-job 32-bit running checksum output.
module glb_host_dma #(
  parameter int DATA_SIZE = 32,
  parameter int LEN_BITS  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [31:0]          cfg_load_base,
  input  logic [31:0]          cfg_drain_base,
  input  logic [LEN_BITS-1:0]  cfg_load_len,
  input  logic [LEN_BITS-1:0]  cfg_drain_len,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DATA_SIZE-1:0] s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DATA_SIZE-1:0] m_data,
  output logic [3:0]           glb_we,
  output logic [3:0]           glb_re,
  output logic [31:0]          glb_w_addr,
  output logic [31:0]          glb_r_addr,
  output logic [DATA_SIZE-1:0] glb_w_data,
  input  logic [DATA_SIZE-1:0] glb_r_data,
  output logic                 acc_start,
  input  logic                 acc_done,
  output logic                 busy,
  output logic                 job_done
`ifdef GLB_DMA_CHKSUM_EN
  ,
  output logic [31:0]          chksum
`endif
);

  typedef enum logic [2:0] {IDLE, LOAD, KICK, WAIT, DRAIN, FINISH} state_t;

  state_t               state, state_nx;
  logic [31:0]          load_base, drain_base;
  logic [LEN_BITS-1:0]  load_len, drain_len;
  logic [LEN_BITS-1:0]  w_cnt, r_cnt, m_cnt;
  logic                 rd_inflight;
  logic [DATA_SIZE-1:0] fifo_mem [2];
  logic                 fifo_wp, fifo_rp;
  logic [1:0]           fifo_cnt;
  logic [1:0]           occ;
  logic [31:0]          w_off, r_off;
  logic                 accept, wr_beat, rd_issue, fifo_pop;

  assign w_off = 32'(w_cnt) << 2;
  assign r_off = 32'(r_cnt) << 2;
  // Buffered words plus the read in flight; a new read only goes out if a FIFO slot is guaranteed.
  assign occ   = fifo_cnt + {1'b0, rd_inflight};

  assign accept   = (state == IDLE) && cfg_valid && !rst;
  assign wr_beat  = (state == LOAD) && s_valid && !rst;
  assign rd_issue = (state == DRAIN) && !rst && (r_cnt != drain_len) && (occ < 2'd2);
  assign fifo_pop = m_valid && m_ready;

  assign cfg_ready  = rst || (state == IDLE);
  assign s_ready    = (state == LOAD) && !rst;
  assign acc_start  = (state == KICK) && !rst;
  assign busy       = (state != IDLE) && !rst;
  assign job_done   = (state == FINISH) && !rst;
  assign m_valid    = (fifo_cnt != 2'd0) && !rst;
  assign m_data     = m_valid ? fifo_mem[fifo_rp] : '0;
  assign glb_we     = wr_beat ? 4'hF : 4'h0;
  assign glb_w_addr = wr_beat ? load_base + w_off : 32'h0;
  assign glb_w_data = wr_beat ? s_data : '0;
  assign glb_re     = rd_issue ? 4'hF : 4'h0;
  assign glb_r_addr = rd_issue ? drain_base + r_off : 32'h0;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (cfg_valid) state_nx = (cfg_load_len == '0) ? KICK : LOAD;
      LOAD:   if (wr_beat && (w_cnt == load_len - 1'b1)) state_nx = KICK;
      KICK:   state_nx = WAIT;
      WAIT:   if (acc_done) state_nx = (drain_len == '0) ? FINISH : DRAIN;
      DRAIN:  if (fifo_pop && (m_cnt == drain_len - 1'b1)) state_nx = FINISH;
      FINISH: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      load_base   <= '0;
      drain_base  <= '0;
      load_len    <= '0;
      drain_len   <= '0;
      w_cnt       <= '0;
      r_cnt       <= '0;
      m_cnt       <= '0;
      rd_inflight <= 1'b0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      fifo_wp     <= 1'b0;
      fifo_rp     <= 1'b0;
      fifo_cnt    <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        load_base  <= cfg_load_base;
        drain_base <= cfg_drain_base;
        load_len   <= cfg_load_len;
        drain_len  <= cfg_drain_len;
        w_cnt      <= '0;
        r_cnt      <= '0;
        m_cnt      <= '0;
      end
      if (wr_beat)  w_cnt <= w_cnt + 1'b1;
      if (rd_issue) r_cnt <= r_cnt + 1'b1;
      // GLB returns read data exactly one cycle after issue.
      rd_inflight <= rd_issue;
      if (rd_inflight) begin
        fifo_mem[fifo_wp] <= glb_r_data;
        fifo_wp           <= ~fifo_wp;
      end
      if (fifo_pop) begin
        fifo_rp <= ~fifo_rp;
        m_cnt   <= m_cnt + 1'b1;
      end
      fifo_cnt <= fifo_cnt + {1'b0, rd_inflight} - {1'b0, fifo_pop};
    end
  end

`ifdef GLB_DMA_CHKSUM_EN
  always_ff @(posedge clk) begin
    if (rst || accept) chksum <= '0;
    else chksum <= chksum + (wr_beat ? 32'(s_data) : 32'h0) + (fifo_pop ? 32'(m_data) : 32'h0);
  end
`endif

endmodule

// File: tb/tb_glb_host_dma.sv
// Randomized bench for glb_host_dma: a job-level model checks every cycle, plus literal scenario checks.
`timescale 1ns/1ps
module tb_glb_host_dma;
  localparam int DW = 32;
  localparam int LB = 16;

  logic          clk = 1'b0, rst = 1'b1;
  logic          cfg_valid = 0, cfg_ready;
  logic [31:0]   cfg_load_base = 0, cfg_drain_base = 0;
  logic [LB-1:0] cfg_load_len = 0, cfg_drain_len = 0;
  logic          s_valid = 0, s_ready, m_valid, m_ready = 0;
  logic [DW-1:0] s_data = 0, m_data, glb_w_data, glb_r_data = 0;
  logic [3:0]    glb_we, glb_re;
  logic [31:0]   glb_w_addr, glb_r_addr;
  logic          acc_start, acc_done = 0, busy, job_done;
`ifdef GLB_DMA_CHKSUM_EN
  logic [31:0]   chksum;
`endif

  always #5 clk = ~clk;

  glb_host_dma #(.DATA_SIZE(DW), .LEN_BITS(LB)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_load_base(cfg_load_base), .cfg_drain_base(cfg_drain_base),
    .cfg_load_len(cfg_load_len), .cfg_drain_len(cfg_drain_len),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .glb_we(glb_we), .glb_re(glb_re), .glb_w_addr(glb_w_addr), .glb_r_addr(glb_r_addr),
    .glb_w_data(glb_w_data), .glb_r_data(glb_r_data),
    .acc_start(acc_start), .acc_done(acc_done), .busy(busy), .job_done(job_done)
`ifdef GLB_DMA_CHKSUM_EN
    , .chksum(chksum)
`endif
  );

  int n_vec = 0, n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // GLB contents: a fixed pattern of the address unless overridden.
  logic [31:0] mem [int unsigned];
  function automatic logic [31:0] gval(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hC0DE0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Stimulus knobs
  int  s_prob = 100, m_mode = 1, mpat_i = 0;
  bit  mpat [6] = '{1, 0, 0, 1, 0, 1};
  bit  want_cfg = 0;
  logic [31:0] q_lb, q_db;
  int  q_ll, q_dl;
  logic [31:0] load_q [$];

  // Job-level model state
  bit  in_job = 0, kicked = 0, done_seen = 0, rd_pend = 0, drain_act;
  logic [31:0] lb, db, rd_addr, sum = 0;
  int  ll, dl, wi, ri, pk, pk0, exp_kick = -1, exp_fin = -1, done_wait = 0;
  int  jobs_done = 0, jd_pulses = 0, glb_acc = 0, max_out = 0, kick_c = 0, lastw_c = 0;
  logic [31:0] wlog_a [$], wlog_d [$], mlog [$];

  task automatic step();
    @(posedge clk); #1;
    s_valid = ($urandom_range(99) < s_prob);
    s_data  = (load_q.size() != 0) ? load_q[0] : $urandom;
    case (m_mode)
      0: m_ready = 1'($urandom_range(1));
      1: m_ready = 1'b1;
      2: begin m_ready = mpat[mpat_i % 6]; mpat_i++; end
      default: m_ready = 1'b0;
    endcase
    glb_r_data = rd_pend ? gval(rd_addr) : $urandom;
    if (kicked && !done_seen) begin
      acc_done = (done_wait == 0);
      if (done_wait > 0) done_wait--;
    end else acc_done = ($urandom_range(7) == 0);
    if (!in_job && want_cfg) begin
      cfg_valid = 1; cfg_load_base = q_lb; cfg_drain_base = q_db;
      cfg_load_len = LB'(q_ll); cfg_drain_len = LB'(q_dl);
    end else if (in_job) begin
      // Junk descriptors while busy must be ignored.
      cfg_valid = 1'($urandom_range(1)); cfg_load_base = $urandom; cfg_drain_base = $urandom;
      cfg_load_len = LB'($urandom); cfg_drain_len = LB'($urandom);
    end else cfg_valid = 0;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_ctrl", {24'h0, cfg_ready, s_ready, m_valid, acc_start, busy, job_done, |glb_we, |glb_re}, 32'h80);
      chk("rst_addr_data", glb_w_addr | glb_r_addr | glb_w_data | m_data, 32'h0);
      in_job = 0; kicked = 0; done_seen = 0; rd_pend = 0; sum = 0;
      exp_kick = -1; exp_fin = -1;
    end else begin
      drain_act = in_job && done_seen && (dl > 0);
      pk0 = pk;
      chk("busy", 32'(busy), 32'(in_job));
      chk("cfg_ready", 32'(cfg_ready), 32'(!in_job));
      chk("job_done", 32'(job_done), 32'(in_job && cyc == exp_fin));
      chk("acc_start", 32'(acc_start), 32'(in_job && cyc == exp_kick));
      chk("s_ready", 32'(s_ready), 32'(in_job && wi < ll));
`ifdef GLB_DMA_CHKSUM_EN
      chk("chksum", chksum, sum);
`endif
      if (job_done) jd_pulses++;
      if (in_job && kicked && !done_seen && acc_done) begin
        done_seen = 1;
        if (dl == 0) exp_fin = cyc + 1;
      end
      if (acc_start) begin kicked = 1; kick_c = cyc; done_wait = $urandom_range(5); end
      // host -> GLB writes
      chk("glb_we", 32'(glb_we), (in_job && wi < ll && s_valid) ? 32'hF : 32'h0);
      if (in_job && wi < ll && s_valid) begin
        chk("w_addr", glb_w_addr, lb + 32'(wi) * 4);
        chk("w_data", glb_w_data, s_data);
        wlog_a.push_back(glb_w_addr); wlog_d.push_back(glb_w_data);
        sum += s_data; wi++; glb_acc++; lastw_c = cyc;
        if (load_q.size() != 0) void'(load_q.pop_front());
        if (wi == ll) exp_kick = cyc + 1;
      end
      // GLB -> host stream
      if (m_valid) chk("m_valid_has_data", 32'(drain_act && ri > pk), 32'h1);
      if (m_valid && m_ready && drain_act && pk < dl) begin
        chk("m_data", m_data, gval(db + 32'(pk) * 4));
        mlog.push_back(m_data); sum += m_data; pk++;
        if (pk == dl) exp_fin = cyc + 1;
      end
      rd_pend = 0;
      if (glb_re != 4'h0) begin
        chk("glb_re_legal", {28'h0, glb_re == 4'hF, drain_act, ri < dl, (ri - pk0) < 2}, 32'hF);
        chk("r_addr", glb_r_addr, db + 32'(ri) * 4);
        rd_pend = 1; rd_addr = db + 32'(ri) * 4; ri++; glb_acc++;
        if (ri - pk0 > max_out) max_out = ri - pk0;
      end
      if (in_job && cyc == exp_fin) begin
        in_job = 0; jobs_done++;
      end else if (!in_job && cfg_valid) begin
        want_cfg = 0; in_job = 1;
        lb = cfg_load_base; db = cfg_drain_base; ll = int'(cfg_load_len); dl = int'(cfg_drain_len);
        wi = 0; ri = 0; pk = 0; kicked = 0; done_seen = 0; sum = 0;
        exp_kick = (cfg_load_len == 0) ? cyc + 1 : -1; exp_fin = -1;
        wlog_a.delete(); wlog_d.delete(); mlog.delete();
      end
    end
  end

  task automatic pulse_rst();
    rst = 1; step(); rst = 0; want_cfg = 0;
  endtask

  task automatic run_job(input logic [31:0] lbase, input int llen, input logic [31:0] dbase, input int dlen);
    int t0, b;
    t0 = jobs_done; b = 0;
    q_lb = lbase; q_ll = llen; q_db = dbase; q_dl = dlen; want_cfg = 1;
    while (jobs_done == t0 && b < 3000) begin step(); b++; end
    chk("job_complete", 32'(jobs_done - t0), 32'h1);
    if (jobs_done == t0) pulse_rst();
    step();
  endtask

  initial begin
    logic [31:0] ea [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
    logic [31:0] ed [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    logic [31:0] em [3] = '{32'hC0DE0100, 32'hC0DE0104, 32'hC0DE0108};
    int jd0, ga0, b;
    mem[32'h200] = 32'd10;
    mem[32'h204] = 32'd20;
    repeat (3) step();
    rst = 0;
    step();

    // Load 4 words at 0x0, drain 3 from 0x100 with m_ready held high
    load_q = '{32'h11, 32'h22, 32'h33, 32'h44};
    s_prob = 100; m_mode = 1; jd0 = jd_pulses;
    run_job(32'h0, 4, 32'h100, 3);
    chk("A_wcount", 32'(wlog_a.size()), 32'd4);
    for (int i = 0; i < 4; i++) if (i < wlog_a.size()) begin
      chk("A_w_addr", wlog_a[i], ea[i]);
      chk("A_w_data", wlog_d[i], ed[i]);
    end
    chk("A_kick_after_last_write", 32'(kick_c - lastw_c), 32'd1);
    chk("A_mcount", 32'(mlog.size()), 32'd3);
    for (int i = 0; i < 3; i++) if (i < mlog.size()) chk("A_m_data", mlog[i], em[i]);
    chk("A_job_done_pulses", 32'(jd_pulses - jd0), 32'd1);

    // Drain under a 1,0,0,1,0,1 m_ready pattern
    m_mode = 2; mpat_i = 0; s_prob = 60; max_out = 0;
    run_job(32'h1000, 3, 32'h2000, 6);
    chk("B_mcount", 32'(mlog.size()), 32'd6);
    if (mlog.size() == 6) chk("B_last_word", mlog[5], 32'hC0DE2014);
    chk("B_max_outstanding_le2", 32'(max_out <= 2), 32'h1);

    // Zero-length load and drain: no GLB traffic
    m_mode = 1; ga0 = glb_acc; jd0 = jd_pulses;
    run_job(32'h300, 0, 32'h400, 0);
    chk("C_glb_accesses", 32'(glb_acc - ga0), 32'h0);
    chk("C_job_done_pulses", 32'(jd_pulses - jd0), 32'd1);

`ifdef GLB_DMA_CHKSUM_EN
    load_q = '{32'd1, 32'd2, 32'd3};
    s_prob = 100; m_mode = 1;
    run_job(32'h40, 3, 32'h200, 2);
    chk("D_chksum", chksum, 32'd36);
`endif

    // Reset mid-drain with both FIFO slots full
    m_mode = 3; s_prob = 100;
    q_lb = 32'h80; q_ll = 2; q_db = 32'h500; q_dl = 5; want_cfg = 1; b = 0;
    while (!(done_seen && ri >= 2) && b < 500) begin step(); b++; end
    repeat (3) step();
    chk("E_reads_before_rst", 32'(ri), 32'd2);
    chk("E_m_valid_before_rst", 32'(m_valid), 32'h1);
    pulse_rst();
    #3;
    chk("E_post_rst", {29'h0, m_valid, busy, cfg_ready}, 32'h1);
    m_mode = 1;
    run_job(32'h600, 4, 32'h700, 4);
    chk("E_new_job_mcount", 32'(mlog.size()), 32'd4);

    // Random jobs, some straddling the 2^32 address wrap
    for (int j = 0; j < 20; j++) begin
      logic [31:0] lbr, dbr;
      lbr = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
      dbr = ($urandom_range(3) == 0) ? 32'hFFFF_FFF4 : ($urandom & 32'hFFFF_FFFC);
      s_prob = $urandom_range(30, 100);
      m_mode = $urandom_range(0, 2); mpat_i = 0;
      q_dl = $urandom_range(0, 8);
      run_job(lbr, $urandom_range(0, 8), dbr, q_dl);
      chk("F_mcount", 32'(mlog.size()), 32'(q_dl));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/glb_host_dma.md
GLB_HOST_DMA -- requirements
Module: glb_host_dma

Interface
REQ-001 Parameter DATA_SIZE, default 32, GLB word and stream width in bits.
REQ-002 Parameter LEN_BITS, default 16, width of the word-count fields.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 cfg_valid  input  1  job descriptor valid.
REQ-006 cfg_ready  output  1  descriptor accepted when high with cfg_valid.
REQ-007 cfg_load_base, cfg_drain_base  input  32 each  GLB byte base addresses, word aligned.
REQ-008 cfg_load_len, cfg_drain_len  input  LEN_BITS each  word counts.
REQ-009 s_valid, s_ready  input/output  1  host-to-GLB stream handshake.
REQ-010 s_data  input  DATA_SIZE  host-to-GLB stream word.
REQ-011 m_valid, m_ready  output/input  1  GLB-to-host stream handshake.
REQ-012 m_data  output  DATA_SIZE  GLB-to-host stream word.
REQ-013 glb_we, glb_re  output  4  GLB byte-lane write and read enables.
REQ-014 glb_w_addr, glb_r_addr  output  32  GLB byte addresses.
REQ-015 glb_w_data  output  DATA_SIZE; glb_r_data  input  DATA_SIZE.
REQ-016 acc_start  output  1  one-cycle accelerator start pulse; acc_done  input  1  accelerator completion.
REQ-017 busy  output  1  job in progress; job_done  output  1  one-cycle pulse at job end.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD, KICK, WAIT, DRAIN, FINISH.
REQ-019 IDLE: cfg_ready=1; a cfg_valid&cfg_ready cycle SHALL latch all four fields and move to LOAD.
REQ-020 LOAD: s_ready=1; each s_valid&s_ready beat SHALL drive glb_we=4'hF, glb_w_addr=load_base+4*i and glb_w_data=s_data combinationally in the same cycle, with i counting from 0.
REQ-021 LOAD SHALL exit to KICK after beat load_len-1; with load_len=0 the FSM SHALL go from IDLE to KICK directly.
REQ-022 KICK SHALL last one cycle with acc_start=1, then go to WAIT.
REQ-023 WAIT SHALL go to DRAIN on acc_done=1; acc_done in any other state SHALL be ignored.
REQ-024 DRAIN: glb_re=4'hF, glb_r_addr=drain_base+4*j SHALL be issued only when (buffered words + reads in flight) < 2; glb_r_data is valid exactly one cycle after the read is issued.
REQ-025 Returned words SHALL enter a 2-entry FIFO, and m_valid/m_data SHALL present its head; words SHALL leave in address order with none lost or duplicated under any m_ready pattern.
REQ-026 DRAIN SHALL go to FINISH once drain_len words have completed the m handshake; with drain_len=0, WAIT SHALL go to FINISH on acc_done.
REQ-027 FINISH SHALL last one cycle with job_done=1, then return to IDLE.
REQ-028 busy SHALL be 1 in every state except IDLE.
REQ-029 Address arithmetic SHALL be 32-bit modulo 2^32, so it wraps silently.
REQ-030 Outside LOAD, s_ready SHALL be 0 and cfg_valid SHALL be ignored while busy.
REQ-031 Outside a write beat, glb_we SHALL be 0; outside a read issue, glb_re SHALL be 0.

Reset
REQ-032 rst=1 SHALL force IDLE in any state, clear counters, FIFO and in-flight flags, and discard buffered drain data.
REQ-033 During and after reset until the next event: cfg_ready=1, s_ready=0, m_valid=0, glb_we=0, glb_re=0, acc_start=0, busy=0, job_done=0.
REQ-034 All address and data outputs SHALL be 0 during reset.

Configuration
REQ-035 Macro GLB_DMA_CHKSUM_EN, when defined, SHALL add output chksum (32 bits), the modulo-2^32 sum of all words accepted in LOAD and all words sent in DRAIN for the current job; chksum SHALL clear on descriptor accept and on reset, and hold its value after FINISH.
REQ-036 Without GLB_DMA_CHKSUM_EN, the chksum port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-037 Scenario: load_base=0x0, load_len=4, words 0x11,0x22,0x33,0x44 -> writes at 0x0,0x4,0x8,0xC with we=4'hF; acc_start pulses one cycle later.
REQ-038 Scenario: drain_base=0x100, drain_len=3, m_ready=1 after acc_done -> m_data 0x100, 0x104, 0x108 contents in order, then job_done pulses exactly once.
REQ-039 Scenario: drain with m_ready toggling 1,0,0,1,0,1 -> every word appears once, in order, and at most 2 reads are ever outstanding.
REQ-040 Scenario: load_len=0, drain_len=0 -> IDLE, KICK, WAIT, then FINISH on acc_done, with no GLB access.
REQ-041 Scenario: rst asserted mid-DRAIN with 2 words buffered -> next cycle m_valid=0, busy=0, cfg_ready=1, and a new job runs cleanly.
REQ-042 Scenario: with GLB_DMA_CHKSUM_EN, loading 1,2,3 and draining 10,20 -> chksum=36.
